// File: rtl/hit_scheduler_if.sv
// Ball-state update port: one request (index + flip/pocket payload) at a time,
// held until the register file acknowledges it.
interface hit_scheduler_if #(
  parameter int IDX_W = 2
);
  logic             updValid;
  logic             updAck;
  logic [IDX_W-1:0] updIdx;
  logic             updFlipX;
  logic             updFlipY;
  logic             updPocket;

  modport master (output updValid, updIdx, updFlipX, updFlipY, updPocket, input updAck);
  modport slave  (input updValid, updIdx, updFlipX, updFlipY, updPocket, output updAck);
endinterface

// File: rtl/hit_scheduler.sv
// Accumulates per-ball hit/pocket events during a frame and replays them, lowest
// ball index first, over the update port after each startOfFrame seen while idle.
module hit_scheduler #(
  parameter int NUM_BALLS   = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int IDX_W       = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic [NUM_BALLS-1:0] hitBall,
  input  logic [NUM_BALLS-1:0] hitFlipX,
  input  logic [NUM_BALLS-1:0] hitFlipY,
  input  logic [NUM_BALLS-1:0] pocketHit,
  input  logic                 clearErr,
  hit_scheduler_if.master      upd,
  output logic                 busy,
  output logic                 frameDone,
  output logic                 overrunErr,
  output logic                 timeoutErr
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, SCAN, WAIT_ACK} state_t;

  state_t               state_q, state_d;
  logic [NUM_BALLS-1:0] cfx_q, cfy_q, cpk_q;
  logic [NUM_BALLS-1:0] wfx_q, wfy_q, wpk_q;
  logic [NUM_BALLS-1:0] new_fx, new_fy, pending;
  logic [IDX_W-1:0]     sel, idx_q;
  logic                 found;
  logic [CNT_W-1:0]     cnt_q;
  logic                 valid_q, fx_q, fy_q, pk_q, done_q, ovr_q, tmo_q;
  logic                 acked, expired;
  logic                 snap, issue, finish, retire, drop;

  assign new_fx  = hitBall & hitFlipX;
  assign new_fy  = hitBall & hitFlipY;
  assign pending = wfx_q | wfy_q | wpk_q;
  assign acked   = valid_q && upd.updAck;
  assign expired = !upd.updAck && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Scan downwards so the last hit wins, leaving the lowest pending index.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        found = 1'b1;
        sel   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (startOfFrame) state_d = SCAN;
      SCAN:     state_d = found ? WAIT_ACK : IDLE;
      WAIT_ACK: if (acked || expired) state_d = SCAN;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != IDLE);
    snap   = (state_q == IDLE) && startOfFrame;
    issue  = (state_q == SCAN) && found;
    finish = (state_q == SCAN) && !found;
    retire = (state_q == WAIT_ACK) && (acked || expired);
    drop   = (state_q == WAIT_ACK) && expired;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfx_q   <= '0;
      cfy_q   <= '0;
      cpk_q   <= '0;
      wfx_q   <= '0;
      wfy_q   <= '0;
      wpk_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      fx_q    <= 1'b0;
      fy_q    <= 1'b0;
      pk_q    <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      // Hits coincident with the snapshot belong to the next frame.
      if (snap) begin
        cfx_q <= new_fx;
        cfy_q <= new_fy;
        cpk_q <= pocketHit;
        wfx_q <= cfx_q;
        wfy_q <= cfy_q;
        wpk_q <= cpk_q;
      end else begin
        cfx_q <= cfx_q | new_fx;
        cfy_q <= cfy_q | new_fy;
        cpk_q <= cpk_q | pocketHit;
        if (retire) begin
          wfx_q[idx_q] <= 1'b0;
          wfy_q[idx_q] <= 1'b0;
          wpk_q[idx_q] <= 1'b0;
        end
      end

      if (issue) begin
        valid_q <= 1'b1;
        idx_q   <= sel;
        pk_q    <= wpk_q[sel];
        fx_q    <= wfx_q[sel] & ~wpk_q[sel];
        fy_q    <= wfy_q[sel] & ~wpk_q[sel];
        cnt_q   <= '0;
      end else if (retire) begin
        valid_q <= 1'b0;
      end else if (state_q == WAIT_ACK) begin
        cnt_q   <= cnt_q + CNT_W'(1);
      end

      done_q <= finish;

      // Error events take priority over a simultaneous clear.
      if (startOfFrame && busy) ovr_q <= 1'b1;
      else if (clearErr)        ovr_q <= 1'b0;
      if (drop)                 tmo_q <= 1'b1;
      else if (clearErr)        tmo_q <= 1'b0;
    end
  end

  assign upd.updValid  = valid_q;
  assign upd.updIdx    = idx_q;
  assign upd.updFlipX  = fx_q;
  assign upd.updFlipY  = fy_q;
  assign upd.updPocket = pk_q;
  assign frameDone     = done_q;
  assign overrunErr    = ovr_q;
  assign timeoutErr    = tmo_q;
endmodule
